// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - FIFO of raw MIPS instruction words with combinational head decode
//
// Purpose:
//   Buffers up to DEPTH 32-bit MIPS instruction words in strict FIFO order.
//   The head entry is split into its instruction fields, classified as R/I/J,
//   and its 16-bit immediate extended to EXT_W bits. A word pushed in one
//   cycle is presented at the head no earlier than the next cycle.
//
// Parameters:
//   DEPTH     number of buffered instructions (power of two, >= 2)
//   EXT_W     width of the extended immediate (>= 16)
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset (clears pointers and count)
//   flush     synchronous discard of every queued instruction
//   in_valid  in_instr holds an instruction to enqueue
//   in_ready  queue has room this cycle (count < DEPTH)
//   in_instr  raw 32-bit instruction word
//   out_valid head entry and its decode are valid (count != 0)
//   out_ready consumer takes the head entry this cycle
//   opcode, rs, rt, rd, shamt, fn, imm, jtarget
//             bit fields of the head entry
//   imm_ext   imm zero-extended for andi/ori/xori, sign-extended otherwise
//   itype     instruction class: 00 R, 01 I, 10 J
//   count     number of entries currently held

module decode_queue #(
    parameter int DEPTH = 4,
    parameter int EXT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [5:0]                 opcode,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [4:0]                 shamt,
    output logic [5:0]                 fn,
    output logic [15:0]                imm,
    output logic [EXT_W-1:0]           imm_ext,
    output logic [25:0]                jtarget,
    output logic [1:0]                 itype,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] ITYPE_R = 2'b00;
    localparam logic [1:0] ITYPE_I = 2'b01;
    localparam logic [1:0] ITYPE_J = 2'b10;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;
    logic [31:0]   head;

    // in_ready looks only at occupancy, so a full queue refuses a push even
    // when the head is being consumed in the same cycle.
    assign in_ready  = (count_q < FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // DEPTH is a power of two, so the AW-bit pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is left unreset: an entry is only ever observed through the
    // out_valid-gated decode below, after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        opcode  = '0;
        rs      = '0;
        rt      = '0;
        rd      = '0;
        shamt   = '0;
        fn      = '0;
        imm     = '0;
        imm_ext = '0;
        jtarget = '0;
        itype   = ITYPE_R;
        if (out_valid) begin
            opcode  = head[31:26];
            rs      = head[25:21];
            rt      = head[20:16];
            rd      = head[15:11];
            shamt   = head[10:6];
            fn      = head[5:0];
            imm     = head[15:0];
            jtarget = head[25:0];

            case (head[31:26])
                6'h00:        itype = ITYPE_R;
                6'h02, 6'h03: itype = ITYPE_J;
                default:      itype = ITYPE_I;
            endcase

            // Logical immediates (andi/ori/xori) are unsigned; everything
            // else treats the immediate as a signed 16-bit quantity.
            case (head[31:26])
                6'h0C, 6'h0D, 6'h0E: imm_ext = EXT_W'(head[15:0]);
                default:             imm_ext = EXT_W'($signed(head[15:0]));
            endcase
        end
    end

endmodule
